// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller for an external dual-port RAM (port A writes, port B reads).
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module dpram_fifo_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned AF_LEVEL = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] AfLevel = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            empty_q, full_q, almost_full_q, rd_valid_q;
    logic            wr_acc, rd_acc;

    assign wr_acc = wr_en & ~full_q & ~rst;
    assign rd_acc = rd_en & ~empty_q & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(wr_acc);
        rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(rd_acc);
        // Pointer difference modulo 2**(ADDR_W+1) is the occupancy.
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= (wr_ptr_d == rd_ptr_d);
            full_q        <= (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                             (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
            almost_full_q <= (count_d >= AfLevel);
            rd_valid_q    <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (wr_en & full_q);
            underflow_q <= underflow_q | (rd_en & empty_q);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign rd_valid    = rd_valid_q;
    // RAM registers q_b on the read edge, so the data lines up with rd_valid.
    assign rd_data     = ram_q_b;

    assign ram_we_a   = wr_acc;
    assign ram_addr_a = wr_ptr_q[ADDR_W-1:0];
    assign ram_data_a = wr_data;
    assign ram_addr_b = rd_ptr_q[ADDR_W-1:0];
    assign ram_we_b   = 1'b0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: queue-based model checked every cycle plus literal checks.
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       full, almost_full, rd_valid, empty;
    logic [7:0] rd_data;
    logic [6:0] count;
    logic [7:0] ram_data_a;
    logic [5:0] ram_addr_a;
    logic       ram_we_a;
    logic [5:0] ram_addr_b;
    logic       ram_we_b;
    logic [7:0] ram_q_b;
`ifdef FIFO_ERR_FLAGS_EN
    logic overflow, underflow;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .almost_full(almost_full),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .count      (count),
        .ram_data_a (ram_data_a),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    // Behavioural 8x64 dual-port RAM with registered port-B output.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy is the queue size; addresses are plain modulo-64 counters.
    logic [7:0] q [$];
    bit         rv_m = 1'b0;
    logic [7:0] exp_rd = 8'h00;
    int         wa_m = 0;
    int         ra_m = 0;
    bit         ovf_m = 1'b0;
    bit         udf_m = 1'b0;

    always @(posedge clk) begin
        bit wa, ra;
        if (rst) begin
            q.delete();
            rv_m = 1'b0;
            wa_m = 0;
            ra_m = 0;
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (wr_en && q.size() == 64) ovf_m = 1'b1;
            if (rd_en && q.size() == 0) udf_m = 1'b1;
            wa = wr_en && (q.size() < 64);
            ra = rd_en && (q.size() > 0);
            rv_m = ra;
            if (ra) begin
                exp_rd = q.pop_front();
                ra_m = (ra_m + 1) % 64;
            end
            if (wa) begin
                q.push_back(wr_data);
                wa_m = (wa_m + 1) % 64;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_we;
        if (chk_en) begin
            check("count", 32'(count), 32'(q.size()));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("full", 32'(full), 32'(q.size() == 64));
            check("almost_full", 32'(almost_full), 32'(q.size() >= 56));
            check("rd_valid", 32'(rd_valid), 32'(rv_m));
            if (rv_m) check("rd_data", 32'(rd_data), 32'(exp_rd));
            exp_we = wr_en && !rst && (q.size() < 64);
            check("ram_we_a", 32'(ram_we_a), 32'(exp_we));
            if (exp_we) begin
                check("ram_addr_a", 32'(ram_addr_a), 32'(wa_m));
                check("ram_data_a", 32'(ram_data_a), 32'(wr_data));
            end
            check("ram_we_b", 32'(ram_we_b), 32'd0);
            check("ram_addr_b", 32'(ram_addr_b), 32'(ra_m));
`ifdef FIFO_ERR_FLAGS_EN
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("underflow", 32'(underflow), 32'(udf_m));
`endif
        end
    end

    task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic r);
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int max_cnt;
        bit seen_wrap;
        int prev_addr;

        // Reset then idle
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_reset_empty", 32'(empty), 32'd1);
        check("lit_reset_full", 32'(full), 32'd0);
        check("lit_reset_count", 32'(count), 32'd0);
        check("lit_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("lit_reset_we_a", 32'(ram_we_a), 32'd0);

        // Three writes, three reads
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 * (i + 1));
            #1;
            check("lit_small_we_a", 32'(ram_we_a), 32'd1);
            check("lit_small_addr_a", 32'(ram_addr_a), 32'(i));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("lit_small_rd_valid", 32'(rd_valid), 32'd1);
            check("lit_small_rd_data", 32'(rd_data), 32'(8'h10 * (i + 1)));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_small_empty", 32'(empty), 32'd1);
        check("lit_small_count", 32'(count), 32'd0);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 54) check("lit_af_below", 32'(almost_full), 32'd0);
            if (i == 55) check("lit_af_at56", 32'(almost_full), 32'd1);
        end
        check("lit_fill_full", 32'(full), 32'd1);
        check("lit_fill_count", 32'(count), 32'd64);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("lit_ovf_count", 32'(count), 32'd64);
`ifdef FIFO_ERR_FLAGS_EN
        check("lit_overflow", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("lit_drain_data", 32'(rd_data), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_drain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        check("lit_both_full_count", 32'(count), 32'd63);
        check("lit_both_full_full", 32'(full), 32'd0);
        check("lit_both_full_data", 32'(rd_data), 32'h40);
        for (int i = 0; i < 63; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_both_drained", 32'(empty), 32'd1);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        check("lit_both_empty_count", 32'(count), 32'd1);
        check("lit_both_empty_rv", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check("lit_underflow", 32'(underflow), 32'd1);
`endif
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("lit_5a_rv", 32'(rd_valid), 32'd1);
        check("lit_5a_data", 32'(rd_data), 32'h5A);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Pointer wrap
        max_cnt = 0;
        seen_wrap = 1'b0;
        prev_addr = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h80 + i);
            rd_en = 1'b0;
            #1;
            if (prev_addr == 63 && ram_addr_a == 6'd0) seen_wrap = 1'b1;
            prev_addr = int'(ram_addr_a);
            @(posedge clk);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check("lit_wrap_seen", 32'(seen_wrap), 32'd1);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("lit_wrap_data", 32'(rd_data), 32'(8'h80 + i));
        end
        check("lit_wrap_max_le40", 32'(max_cnt <= 40), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-operation
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        wr_en = 1'b1;
        wr_data = 8'h77;
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        check("lit_rst_rd_valid", 32'(rd_valid), 32'd1);
        check("lit_rst_rd_data", 32'(rd_data), 32'h33);
        check("lit_rst_we_a", 32'(ram_we_a), 32'd0);
        @(posedge clk);
        #1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_post_rst_empty", 32'(empty), 32'd1);
        check("lit_post_rst_count", 32'(count), 32'd0);
        check("lit_post_rst_rv", 32'(rd_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the team's 8x64 dual-port RAM.
- RAM port A is used as the write port only.
- RAM port B is used as the read port only.
- The RAM itself stays external. This block owns the pointers, occupancy count, flags and the read-valid timing, and sits directly upstream of the RAM instance.
- Producer and consumer are on the same clock.

Parameters:
DATA_W, 8, data width; matches RAM word width
ADDR_W, 6, RAM address width; FIFO depth = 2**ADDR_W = 64
AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
wr_en  input  1  producer write request
wr_data  input  DATA_W  producer write data
full  output  1  FIFO holds 2**ADDR_W entries
almost_full  output  1  count >= AF_LEVEL
rd_en  input  1  consumer read request
rd_data  output  DATA_W  read data; valid when rd_valid=1
rd_valid  output  1  rd_data carries the word popped on the previous cycle
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
ram_data_a  output  DATA_W  to RAM data_a
ram_addr_a  output  ADDR_W  to RAM addr_a
ram_we_a  output  1  to RAM we_a
ram_addr_b  output  ADDR_W  to RAM addr_b
ram_we_b  output  1  to RAM we_b; tied 0
ram_q_b  input  DATA_W  from RAM q_b

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, rd_valid=0.
  - empty=1, full=0, almost_full=0.
  - RAM contents are not cleared.
  - rst has priority over every other input.
  - ram_we_a is forced to 0 while rst=1.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits. The low ADDR_W bits address the RAM. The MSB is the wrap bit.
- Flags are registered:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Write accept: wr_acc = wr_en & ~full & ~rst.
  - Combinational: ram_we_a = wr_acc, ram_addr_a = wr_ptr[ADDR_W-1:0], ram_data_a = wr_data.
  - On wr_acc, wr_ptr increments at the posedge.
- Read accept: rd_acc = rd_en & ~empty & ~rst.
  - Combinational: ram_addr_b = rd_ptr[ADDR_W-1:0]; ram_we_b = 0 always.
  - On rd_acc, rd_ptr increments.
  - rd_valid <= rd_acc, so it is high exactly one cycle after the accepted read.
  - rd_data = ram_q_b (pass-through). The RAM registers q_b on the same edge, giving a read latency of 1 clock.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- Simultaneous wr_en & rd_en:
  - When full: read accepted, write rejected. full deasserts next cycle; count goes to 63.
  - When empty: write accepted, read rejected (no fall-through). empty deasserts next cycle; count goes to 1.
  - Otherwise: both accepted.
- Rejected requests (write when full, read when empty) are dropped silently. No pointer, count or RAM change.
- Wrap-around: pointer low bits wrap 63->0; the MSB toggles.
- Reset mid-operation:
  - A read accepted in the cycle before rst still produces rd_valid=1 in the rst cycle.
  - rd_valid=0 from the cycle after rst.
  - No write reaches RAM while rst=1.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: adds output ports overflow (1) and underflow (1), both sticky, reset to 0.
  - overflow sets at posedge when wr_en & full.
  - underflow sets at posedge when rd_en & empty.
  - Only rst clears them.
- Undefined: ports absent; rejected requests leave no trace.

Test Plan:
- Reset, then idle 2 cycles -> empty=1, full=0, count=0, rd_valid=0, ram_we_a=0.
- Write 0x10,0x20,0x30 on consecutive cycles, then read 3 -> ram_addr_a 0,1,2 with ram_we_a=1; rd_valid on the 3 cycles following the reads with rd_data 0x10,0x20,0x30; empty=1 at end, count=0.
- Write 64 words 0x00..0x3F -> full=1 and count=64 after the 64th; almost_full=1 from count=56; a 65th write with data 0xFF is dropped (overflow=1 if FIFO_ERR_FLAGS_EN). Read all 64 -> data 0x00..0x3F in order.
- Full FIFO, wr_en=rd_en=1 one cycle -> read accepted, write rejected, count=63, full=0. Empty FIFO, wr_en=rd_en=1 with data 0x5A -> count=1, rd_valid=0 next cycle; the following read returns 0x5A.
- Pointer wrap: fill 40, drain 40, then write/read 40 more (values 0x80..0xA7) -> ram_addr_a wraps 63->0; data returned in order; count never exceeds 40.
- rd_en asserted for 1 cycle, then rst asserted the next cycle while wr_en=1 -> rd_valid=1 in the rst cycle; ram_we_a=0 during rst; afterwards empty=1 and count=0.
